// File: rtl/baccarat_match_fsm.sv
// baccarat_match_fsm: sequences card loads for each baccarat round and keeps the match score.
module baccarat_match_fsm #(
    parameter int ROUNDS  = 5,
    parameter int TALLY_W = 4
) (
    input  logic               slow_clock,
    input  logic               resetb,
    input  logic [3:0]         pscore,
    input  logic [3:0]         dscore,
    input  logic [3:0]         pcard3,
    input  logic               next_round,
    output logic               load_pcard1,
    output logic               load_pcard2,
    output logic               load_pcard3,
    output logic               load_dcard1,
    output logic               load_dcard2,
    output logic               load_dcard3,
    output logic               clear_hands,
    output logic               player_win_light,
    output logic               dealer_win_light,
    output logic [TALLY_W-1:0] player_rounds,
    output logic [TALLY_W-1:0] dealer_rounds,
    output logic [TALLY_W-1:0] ties,
    output logic [TALLY_W-1:0] round_num,
    output logic               match_over,
    output logic               match_player_light,
    output logic               match_dealer_light
);
    localparam logic [TALLY_W-1:0] LIMIT = TALLY_W'(ROUNDS);

    typedef enum logic [3:0] {
        CLEAR, P1, D1, P2, D2, DECIDE, P3, DECIDE_D, D3, SCORE, WAIT, DONE
    } state_t;

    state_t state, state_next;
    logic natural, dealer_draw;

    function automatic logic [TALLY_W-1:0] inc(input logic [TALLY_W-1:0] v);
        return (v == '1) ? v : v + 1'b1;
    endfunction

    assign natural = (pscore >= 4'd8) || (dscore >= 4'd8);

    // Dealer third-card table, keyed on the player's third card
    assign dealer_draw = (dscore <= 4'd2)
                      || (dscore == 4'd3 && pcard3 != 4'd8)
                      || (dscore == 4'd4 && pcard3 >= 4'd2 && pcard3 <= 4'd7)
                      || (dscore == 4'd5 && pcard3 >= 4'd4 && pcard3 <= 4'd7)
                      || (dscore == 4'd6 && pcard3 >= 4'd6 && pcard3 <= 4'd7);

    always_ff @(posedge slow_clock or negedge resetb) begin
        if (!resetb)
            state <= CLEAR;
        else
            state <= state_next;
    end

    always_comb begin
        state_next = CLEAR;
        case (state)
            CLEAR:    state_next = P1;
            P1:       state_next = D1;
            D1:       state_next = P2;
            P2:       state_next = D2;
            D2:       state_next = DECIDE;
            DECIDE:   state_next = natural ? SCORE :
                                   (pscore <= 4'd5) ? P3 :
                                   (dscore <= 4'd5) ? D3 : SCORE;
            P3:       state_next = DECIDE_D;
            DECIDE_D: state_next = dealer_draw ? D3 : SCORE;
            D3:       state_next = SCORE;
            SCORE:    state_next = WAIT;
            WAIT:     state_next = (round_num == LIMIT) ? DONE :
                                   next_round ? CLEAR : WAIT;
            DONE:     state_next = DONE;
            default:  state_next = CLEAR;
        endcase
    end

    always_comb begin
        clear_hands        = (state == CLEAR);
        load_pcard1        = (state == P1);
        load_dcard1        = (state == D1);
        load_pcard2        = (state == P2);
        load_dcard2        = (state == D2);
        load_pcard3        = (state == P3);
        load_dcard3        = (state == D3);
        match_over         = (state == DONE);
        match_player_light = match_over && (player_rounds >= dealer_rounds);
        match_dealer_light = match_over && (dealer_rounds >= player_rounds);
    end

    // Round result is latched as SCORE is left and held until the next CLEAR
    always_ff @(posedge slow_clock or negedge resetb) begin
        if (!resetb) begin
            player_win_light <= 1'b0;
            dealer_win_light <= 1'b0;
            player_rounds    <= '0;
            dealer_rounds    <= '0;
            ties             <= '0;
            round_num        <= '0;
        end else if (state == SCORE) begin
            player_win_light <= pscore >= dscore;
            dealer_win_light <= dscore >= pscore;
            player_rounds    <= (pscore > dscore) ? inc(player_rounds) : player_rounds;
            dealer_rounds    <= (pscore < dscore) ? inc(dealer_rounds) : dealer_rounds;
            ties             <= (pscore == dscore) ? inc(ties) : ties;
            round_num        <= inc(round_num);
        end else if (state_next == CLEAR) begin
            player_win_light <= 1'b0;
            dealer_win_light <= 1'b0;
        end
    end
endmodule
